bit_serializer: RTL
===================

// Module: bit_serializer
// PURPOSE
//  Upstream feeder for the serial pattern-detector FSM. Accepts parallel words over a
//  valid/ready handshake and shifts them out one bit per clock on x_out/x_valid.
//  A one-word holding buffer makes back-to-back words serialise with no gap.
//  The detector's x input connects directly to x_out.
// PARAMETERS
//  WIDTH      8   bits per word; legal range is 2..32
//  MSB_FIRST  1   1 = shift MSB first; 0 = shift LSB first
//  IDLE_BIT   0   value driven on x_out while x_valid=0
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      synchronous, active-low reset
//  in_data    in   WIDTH  parallel word to serialise
//  in_valid   in   1      in_data is valid this cycle
//  in_ready   out  1      block accepts in_data this cycle
//  x_out      out  1      serial bit (registered)
//  x_valid    out  1      x_out carries a data bit (registered)
//  frame_done out  1      1-cycle pulse, coincident with the last bit of a word
//  busy       out  1      shifter active OR hold buffer full
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge):
//   - hold_full=0, state=IDLE, bit count=0.
//   - x_out=IDLE_BIT, x_valid=0, frame_done=0, busy=0.
//   - in_ready=0 while reset_n=0.
//  Reset mid-word: the partial word and any held word are discarded.
//   Outputs return to their idle values at that edge. No frame_done is issued.
//  Handshake:
//   - in_ready = reset_n & ~hold_full. This is combinational from registers only and
//     does not depend on in_valid.
//   - Transfer occurs when in_valid & in_ready at a clk edge. in_data is captured
//     into the hold register and hold_full is set.
//   - in_data is ignored when no transfer occurs.
//  State machine, two states:
//   - IDLE:  x_valid=0. If hold_full, load the shifter from hold, clear hold_full,
//     set cnt=WIDTH-1, and go to SHIFT.
//   - SHIFT: x_valid=1 and x_out = current bit.
//     - If cnt>0: shift one bit per clock and decrement cnt.
//     - If cnt==0 (last bit): frame_done=1 this cycle. At the edge, if hold_full,
//       reload the shifter (cnt=WIDTH-1, stay in SHIFT, no idle cycle). Otherwise
//       go to IDLE.
//  Simultaneous load and accept: hold may be emptied into the shifter and refilled by
//   a new transfer at the same edge only if in_ready was 1 in that cycle. Because
//   in_ready = ~hold_full, a full hold cannot accept.
//  Latency: word accepted at edge E0 -> first bit valid after E1 (shifter idle).
//   The last bit is valid after E(WIDTH). frame_done is high in that same cycle.
//  Throughput: one word per WIDTH cycles sustained, with a continuous x_valid stream.
//  Bit order:
//   - MSB_FIRST=1: bits in_data[WIDTH-1] down to [0].
//   - MSB_FIRST=0: bits [0] up to [WIDTH-1].
//  busy = x_valid | hold_full. No X is allowed on any output after the first reset.
// TESTING
//  T1 reset: hold reset_n=0 for 3 clocks -> x_valid=0, x_out=0, frame_done=0,
//     in_ready=0. Release reset -> in_ready=1.
//  T2 single word 8'hB5, MSB_FIRST=1 -> x_out 1,0,1,1,0,1,0,1 on 8 consecutive
//     x_valid cycles, starting 1 cycle after accept. frame_done only on the 8th bit.
//     The attached detector sees 1011.
//  T3 back-to-back words 8'hB5 then 8'h0F, in_valid held high -> 16 contiguous x_valid
//     cycles. in_ready drops after the second accept and rises after the reload edge.
//     frame_done fires twice.
//  T4 backpressure: in_valid=1 while hold is full -> in_ready=0 and the word is not
//     taken. in_data changes while in_ready=0 -> those values never appear on x_out.
//  T5 MSB_FIRST=0 with word 8'h01 -> x_out 1,0,0,0,0,0,0,0.
//  T6 reset asserted at bit 4 of a word with hold full -> next cycle x_valid=0 and
//     no frame_done. A fresh word afterwards serialises correctly.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the pattern detector.
// One-word hold buffer lets consecutive words stream without a gap.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_x_out;
  logic             r_x_valid;
  logic             r_frame_done;

  state_t           w_state;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    w_cnt;
  logic             w_load;
  logic             w_accept;
  logic             w_hold_full;
  logic             w_bit;
  logic             w_active;

  assign in_ready = reset_n & ~r_hold_full;
  assign w_accept = in_valid & in_ready;

  assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shift[WIDTH-1:1]};

  always_comb begin
    w_load  = 1'b0;
    w_state = r_state;
    w_shift = r_shift;
    w_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (r_hold_full) w_load = 1'b1;
      end
      S_SHIFT: begin
        if (r_cnt != '0) begin
          w_shift = w_shifted;
          w_cnt   = r_cnt - 1'b1;
        end else if (r_hold_full) begin
          w_load = 1'b1;
        end else begin
          w_state = S_IDLE;
        end
      end
    endcase
    // Reload from hold takes priority over the idle/shift decision.
    if (w_load) begin
      w_shift = r_hold;
      w_cnt   = CW'(WIDTH - 1);
      w_state = S_SHIFT;
    end
  end

  assign w_hold_full = w_accept | (r_hold_full & ~w_load);
  assign w_active    = (w_state == S_SHIFT);
  assign w_bit       = MSB_FIRST ? w_shift[WIDTH-1] : w_shift[0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_x_out      <= IDLE_BIT;
      r_x_valid    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_hold_full  <= w_hold_full;
      r_shift      <= w_shift;
      r_cnt        <= w_cnt;
      r_x_valid    <= w_active;
      r_x_out      <= w_active ? w_bit : IDLE_BIT;
      r_frame_done <= w_active && (w_cnt == '0);
      if (w_accept) r_hold <= in_data;
    end
  end

  assign x_out      = r_x_out;
  assign x_valid    = r_x_valid;
  assign frame_done = r_frame_done;
  assign busy       = r_x_valid | r_hold_full;

endmodule
